pwr_mode_scheduler: RTL and testbench
=====================================

PWR_MODE_SCHEDULER -- requirements
Module: pwr_mode_scheduler

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles needed to accept a new level on a synchronized input (legal range 2..65535).
REQ-002 Parameter SEQ_TIMEOUT, default 1024: maximum cycles to wait for seq_done after a command is accepted (legal range 2..2^20).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 onoff_in  input  1  raw user on/off switch, asynchronous (1 = on requested).
REQ-006 lpm_in  input  1  raw low-power-mode request, asynchronous.
REQ-007 lbd_in  input  1  raw low-battery detect, asynchronous.
REQ-008 cmd_ready  input  1  rail sequencer accepts a command.
REQ-009 seq_done  input  1  one-cycle pulse: rail sequencer finished the accepted command.
REQ-010 cmd_valid  output  1  command offered to the rail sequencer.
REQ-011 cmd  output  2  command code: 00 ON, 01 OFF, 10 LOWPOWER; 11 never driven.
REQ-012 mode  output  2  settled power mode: 00 OFF, 01 ON, 10 LOWPOWER, 11 LB_LOCKOUT.
REQ-013 busy  output  1  high while in ISSUE or WAIT.
REQ-014 timeout_err  output  1  sticky sequencer-timeout flag.

Function
REQ-015 Each raw input passes through a 2-flop synchronizer, then a per-input debounce counter; filtered level changes only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-016 Debounce latency: a clean raw edge appears on the filtered level exactly 2+DEB_CYCLES rising edges after the first edge sampling it.
REQ-017 Target mode, combinational from filtered levels, priority order: lbd_f=1 -> LB_LOCKOUT; else onoff_f=0 -> OFF; else lpm_f=1 -> LOWPOWER; else ON.
REQ-018 Target-to-command map: ON->00, LOWPOWER->10, OFF and LB_LOCKOUT->01.
REQ-019 FSM states: IDLE, ISSUE, WAIT, ERROR.
REQ-020 IDLE: target==mode -> stay; target and mode both in {OFF, LB_LOCKOUT} -> mode<=target next edge, no command, stay IDLE; else latch cmd from target, go ISSUE (cmd_valid high the cycle after the mismatch is first seen).
REQ-021 ISSUE: cmd_valid=1, cmd held stable; transfer occurs on an edge with cmd_ready=1; then go WAIT, cmd_valid=0 next cycle, timeout counter cleared.
REQ-022 Target changes during ISSUE or WAIT are not acted upon; the latched command completes and IDLE re-evaluates afterward.
REQ-023 WAIT: counter increments each cycle; seq_done=1 -> mode<=latched target (LB_LOCKOUT if latched target was LB_LOCKOUT), go IDLE.
REQ-024 WAIT timeout: counter reaching SEQ_TIMEOUT without seq_done -> go ERROR, timeout_err<=1; seq_done on that same edge wins (normal completion, no error).
REQ-025 seq_done outside WAIT is ignored.
REQ-026 ERROR: cmd_valid=0, busy=0, mode unchanged, timeout_err=1; exit only by reset.
REQ-027 ON<->LOWPOWER transitions are issued directly without passing through OFF.
REQ-028 busy=1 exactly when state is ISSUE or WAIT.

Reset
REQ-029 reset asserted: immediately state=IDLE, cmd_valid=0, cmd=01, mode=00, busy=0, timeout_err=0, synchronizer flops, filtered levels and all counters 0.
REQ-030 Reset mid-ISSUE or mid-WAIT abandons the command without any further cmd_valid pulse; after release, filtered levels requalify from 0.

Verification
REQ-031 DEB_CYCLES=4, SEQ_TIMEOUT=32, cmd_ready=1: onoff_in 0->1 -> cmd_valid=1 with cmd=00 on edge 7 after change for one cycle; seq_done 5 cycles later -> mode=01, busy=0.
REQ-032 onoff_in glitches high 3 cycles then low -> no cmd_valid, mode stays 00.
REQ-033 mode=01, lbd_in and lpm_in rise together -> single cmd=01 issued, after seq_done mode=11; onoff_in toggle while lbd high -> no command.
REQ-034 cmd_ready held 0 for 10 cycles in ISSUE -> cmd_valid and cmd stable all 10 cycles; transfer on first cmd_ready=1 edge.
REQ-035 No seq_done for 32 cycles in WAIT -> state ERROR, timeout_err=1, no further commands until reset; repeat with seq_done on cycle 32 -> mode updates, timeout_err=0.
REQ-036 reset pulsed during WAIT -> all outputs at reset values in the same cycle, late seq_done ignored.

Source files
------------

// File: rtl/pwr_mode_scheduler.sv
// Power-mode scheduler: synchronises and debounces the on/off, low-power and low-battery
// inputs, then sequences rail commands until the settled mode matches the prioritised target.
module pwr_mode_scheduler #(
    parameter int DEB_CYCLES  = 16,
    parameter int SEQ_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       onoff_in,
    input  logic       lpm_in,
    input  logic       lbd_in,
    input  logic       cmd_ready,
    input  logic       seq_done,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    output logic [1:0] mode,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_ON  = 2'b01;
    localparam logic [1:0] MODE_LP  = 2'b10;
    localparam logic [1:0] MODE_LB  = 2'b11;
    localparam logic [1:0] CMD_ON   = 2'b00;
    localparam logic [1:0] CMD_OFF  = 2'b01;
    localparam logic [1:0] CMD_LP   = 2'b10;

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES);
    localparam logic [20:0] TMO_LAST = 21'(SEQ_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERROR} state_t;

    // bit 0 on/off, bit 1 low-power request, bit 2 low-battery detect
    logic [2:0] raw;
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] filt;

    assign raw = {lbd_in, lpm_in, onoff_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_deb
        logic [15:0] cnt_q;
        logic        filt_q;

        // Any cycle where the synchronised level matches the filtered one restarts the count.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
            end else if (sync2_q[g] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q + 16'd1 == DEB_LAST) begin
                cnt_q  <= '0;
                filt_q <= sync2_q[g];
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign filt[g] = filt_q;
    end

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [1:0]  tgt_q, tgt_d;
    logic [20:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [1:0]  target;
    logic [1:0]  target_cmd;
    logic        target_quiet;
    logic        mode_quiet;

    always_comb begin
        if (filt[2])       target = MODE_LB;
        else if (!filt[0]) target = MODE_OFF;
        else if (filt[1])  target = MODE_LP;
        else               target = MODE_ON;
    end

    always_comb begin
        case (target)
            MODE_ON: target_cmd = CMD_ON;
            MODE_LP: target_cmd = CMD_LP;
            default: target_cmd = CMD_OFF;
        endcase
    end

    // OFF and LB_LOCKOUT share the same rail state, so moving between them needs no command.
    assign target_quiet = (target == MODE_OFF) || (target == MODE_LB);
    assign mode_quiet   = (mode_q == MODE_OFF) || (mode_q == MODE_LB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_OFF;
            cmd_q   <= CMD_OFF;
            tgt_q   <= MODE_OFF;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
            tgt_q   <= tgt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cmd_d   = cmd_q;
        tgt_d   = tgt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (target != mode_q) begin
                    if (target_quiet && mode_quiet) begin
                        mode_d = target;
                    end else begin
                        cmd_d   = target_cmd;
                        tgt_d   = target;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d = S_WAIT;
                    tmo_d   = '0;
                end
            end
            S_WAIT: begin
                // A completion on the timeout edge still counts as a normal finish.
                if (seq_done) begin
                    mode_d  = tgt_q;
                    state_d = S_IDLE;
                end else if (tmo_q + 21'd1 == TMO_LAST) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 21'd1;
                end
            end
            default: state_d = state_q;
        endcase
    end

    assign cmd_valid   = (state_q == S_ISSUE);
    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign cmd         = cmd_q;
    assign mode        = mode_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_pwr_mode_scheduler.sv
// Scenario bench for pwr_mode_scheduler with DEB_CYCLES=4, SEQ_TIMEOUT=32; a negedge monitor
// pops the expected command queue on every accepted transfer.
`timescale 1ns/1ps
module tb_pwr_mode_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       onoff_in = 1'b0;
    logic       lpm_in = 1'b0;
    logic       lbd_in = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       seq_done = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [1:0] mode;
    logic       busy;
    logic       timeout_err;

    int         total = 0;
    int         bad = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;

    pwr_mode_scheduler #(.DEB_CYCLES(4), .SEQ_TIMEOUT(32)) dut (
        .clk(clk), .reset(reset), .onoff_in(onoff_in), .lpm_in(lpm_in), .lbd_in(lbd_in),
        .cmd_ready(cmd_ready), .seq_done(seq_done), .cmd_valid(cmd_valid), .cmd(cmd),
        .mode(mode), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL xfer_unexpected: cmd=%b transferred, required no command", cmd);
            end else begin
                mon_exp = exp_q.pop_front();
                if (cmd !== mon_exp) begin
                    bad++;
                    $display("FAIL xfer_cmd: got %b, required %b", cmd, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(input string name);
        int n;
        n = 0;
        while (cmd_valid !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        total++;
        if (cmd_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_cmd_wait: cmd_valid=%b after %0d cycles, required 1", name, cmd_valid, n);
        end
    endtask

    task automatic complete();
        tick(2);
        seq_done = 1'b1;
        tick(1);
        seq_done = 1'b0;
    endtask

    task automatic test_reset();
        tick(2);
        total++;
        if ({cmd_valid, cmd, mode, busy, timeout_err} !== 7'b0_01_00_0_0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, required 0_01_00_0_0",
                     {cmd_valid, cmd, mode, busy, timeout_err});
        end
        reset = 1'b0;
        tick(3);
        total++;
        if ({cmd_valid, mode, busy} !== 4'b0_00_0) begin
            bad++;
            $display("FAIL reset_idle: got %b, required 0_00_0", {cmd_valid, mode, busy});
        end
    endtask

    task automatic test_glitch();
        onoff_in = 1'b1;
        tick(3);
        onoff_in = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            total++;
            if (cmd_valid !== 1'b0 || busy !== 1'b0 || mode !== 2'b00) begin
                bad++;
                $display("FAIL glitch_quiet: cyc %0d valid=%b busy=%b mode=%b, required 0 0 00",
                         i, cmd_valid, busy, mode);
            end
        end
    endtask

    task automatic test_power_on();
        onoff_in = 1'b1;
        exp_q.push_back(2'b00);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            total++;
            if (cmd_valid !== 1'b0) begin
                bad++;
                $display("FAIL pwr_on_early: edge %0d cmd_valid=%b, required 0", k, cmd_valid);
            end
        end
        tick(1);
        total++;
        if ({cmd_valid, cmd, busy} !== 4'b1_00_1) begin
            bad++;
            $display("FAIL pwr_on_issue: got %b, required 1_00_1", {cmd_valid, cmd, busy});
        end
        tick(1);
        total++;
        if ({cmd_valid, busy, mode} !== 4'b0_1_00) begin
            bad++;
            $display("FAIL pwr_on_wait: got %b, required 0_1_00", {cmd_valid, busy, mode});
        end
        tick(4);
        seq_done = 1'b1;
        tick(1);
        seq_done = 1'b0;
        total++;
        if ({mode, busy} !== 3'b01_0) begin
            bad++;
            $display("FAIL pwr_on_done: mode=%b busy=%b, required 01 0", mode, busy);
        end
    endtask

    task automatic test_lowbat();
        lbd_in = 1'b1;
        lpm_in = 1'b1;
        exp_q.push_back(2'b01);
        wait_cmd("lowbat");
        tick(1);
        complete();
        total++;
        if ({mode, busy} !== 3'b11_0) begin
            bad++;
            $display("FAIL lowbat_mode: mode=%b busy=%b, required 11 0", mode, busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (i == 0) onoff_in = 1'b0;
            if (i == 20) onoff_in = 1'b1;
            tick(1);
            total++;
            if (cmd_valid !== 1'b0 || mode !== 2'b11) begin
                bad++;
                $display("FAIL lowbat_locked: cyc %0d valid=%b mode=%b, required 0 11",
                         i, cmd_valid, mode);
            end
        end
    endtask

    task automatic test_lpm_transitions();
        lbd_in = 1'b0;
        exp_q.push_back(2'b10);
        wait_cmd("to_lp");
        tick(1);
        complete();
        total++;
        if (mode !== 2'b10) begin
            bad++;
            $display("FAIL to_lp_mode: mode=%b, required 10", mode);
        end
        lpm_in = 1'b0;
        exp_q.push_back(2'b00);
        wait_cmd("lp_to_on");
        tick(1);
        total++;
        if ({busy, mode} !== 3'b1_10) begin
            bad++;
            $display("FAIL lp_to_on_wait: busy=%b mode=%b, required 1 10", busy, mode);
        end
        complete();
        total++;
        if (mode !== 2'b01) begin
            bad++;
            $display("FAIL lp_to_on_mode: mode=%b, required 01", mode);
        end
    endtask

    task automatic test_backpressure();
        cmd_ready = 1'b0;
        lpm_in = 1'b1;
        exp_q.push_back(2'b10);
        wait_cmd("bp");
        for (int i = 0; i < 10; i++) begin
            if (i == 0) lpm_in = 1'b0;
            tick(1);
            total++;
            if ({cmd_valid, cmd, busy} !== 4'b1_10_1) begin
                bad++;
                $display("FAIL bp_hold: cyc %0d got %b, required 1_10_1", i, {cmd_valid, cmd, busy});
            end
        end
        cmd_ready = 1'b1;
        tick(1);
        total++;
        if ({cmd_valid, busy} !== 2'b01) begin
            bad++;
            $display("FAIL bp_xfer: valid=%b busy=%b, required 0 1", cmd_valid, busy);
        end
        complete();
        total++;
        if (mode !== 2'b10) begin
            bad++;
            $display("FAIL bp_latched_mode: mode=%b, required 10", mode);
        end
        exp_q.push_back(2'b00);
        wait_cmd("bp_reeval");
        tick(1);
        complete();
        total++;
        if (mode !== 2'b01) begin
            bad++;
            $display("FAIL bp_reeval_mode: mode=%b, required 01", mode);
        end
    endtask

    task automatic test_timeout();
        lpm_in = 1'b1;
        exp_q.push_back(2'b10);
        wait_cmd("tmo");
        tick(1);
        tick(31);
        total++;
        if ({busy, timeout_err} !== 2'b10) begin
            bad++;
            $display("FAIL tmo_early: busy=%b err=%b, required 1 0", busy, timeout_err);
        end
        tick(1);
        total++;
        if ({timeout_err, busy, cmd_valid, mode} !== 5'b1_0_0_01) begin
            bad++;
            $display("FAIL tmo_error: got %b, required 1_0_0_01", {timeout_err, busy, cmd_valid, mode});
        end
        lpm_in = 1'b0;
        onoff_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            total++;
            if ({cmd_valid, busy, timeout_err, mode} !== 5'b0_0_1_01) begin
                bad++;
                $display("FAIL tmo_stuck: cyc %0d got %b, required 0_0_1_01",
                         i, {cmd_valid, busy, timeout_err, mode});
            end
        end
        reset = 1'b1;
        tick(1);
        total++;
        if ({timeout_err, mode} !== 3'b0_00) begin
            bad++;
            $display("FAIL tmo_reset: err=%b mode=%b, required 0 00", timeout_err, mode);
        end
        reset = 1'b0;
    endtask

    task automatic test_timeout_edge();
        onoff_in = 1'b1;
        exp_q.push_back(2'b00);
        wait_cmd("tmo_edge");
        tick(1);
        tick(31);
        seq_done = 1'b1;
        tick(1);
        seq_done = 1'b0;
        total++;
        if ({mode, timeout_err, busy} !== 4'b01_0_0) begin
            bad++;
            $display("FAIL tmo_edge_done: got %b, required 01_0_0", {mode, timeout_err, busy});
        end
    endtask

    task automatic test_reset_mid_wait();
        lpm_in = 1'b1;
        exp_q.push_back(2'b10);
        wait_cmd("rst_wait");
        tick(1);
        tick(3);
        reset = 1'b1;
        #1;
        total++;
        if ({cmd_valid, cmd, mode, busy, timeout_err} !== 7'b0_01_00_0_0) begin
            bad++;
            $display("FAIL rst_wait_async: got %b, required 0_01_00_0_0",
                     {cmd_valid, cmd, mode, busy, timeout_err});
        end
        tick(2);
        reset = 1'b0;
        seq_done = 1'b1;
        tick(1);
        seq_done = 1'b0;
        total++;
        if ({mode, busy, timeout_err} !== 4'b00_0_0) begin
            bad++;
            $display("FAIL rst_wait_late_done: got %b, required 00_0_0", {mode, busy, timeout_err});
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            total++;
            if (cmd_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_wait_requal: cyc %0d cmd_valid=%b, required 0", i, cmd_valid);
            end
        end
        exp_q.push_back(2'b10);
        wait_cmd("rst_reissue");
        tick(1);
        complete();
        total++;
        if (mode !== 2'b10) begin
            bad++;
            $display("FAIL rst_reissue_mode: mode=%b, required 10", mode);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_power_on();
        test_lowbat();
        test_lpm_transitions();
        test_backpressure();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_wait();
        tick(5);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: %0d commands never transferred, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
